// File: rtl/key_wr_arb_pkg.sv
// Shared types and constants for the two-requester AXI write arbiter.
// Optional response watchdog is enabled by defining KEY_WR_ARB_TMO_EN.
package key_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         TMO_CYC_DEF = 4096;

endpackage : key_wr_arb_pkg

// File: rtl/key_wr_arb_if.sv
// AXI4 write channels (AW, W, B) between the arbiter (master) and memory side (slave).
interface key_wr_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512
);

  logic [ADDR_W-1:0]   m_awaddr;
  logic [7:0]          m_awlen;
  logic                m_awvalid;
  logic                m_awready;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wlast;
  logic                m_wvalid;
  logic                m_wready;
  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;

  modport master (
    output m_awaddr, m_awlen, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready
  );

  modport slave (
    input  m_awaddr, m_awlen, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready
  );

endinterface : key_wr_arb_if

// File: rtl/key_wr_arb_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to the requester
// not granted last. ptr holds the index of the last granted requester.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    gnt     = 2'b00;
    ptr_nxt = ptr;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    if (gnt != 2'b00) ptr_nxt = gnt[1];
  end

endmodule : rr_arb2

// File: rtl/key_wr_arb.sv
// Arbitrates two burst writers onto one AXI4 write master port, one burst at a time.
// Define KEY_WR_ARB_TMO_EN to add a write-response watchdog of TMO_CYC cycles.
module key_wr_arb
  import key_wr_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 512,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [1:0]             req,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][7:0]        req_len,
  output logic [1:0]             gnt,
  input  logic [1:0][DATA_W-1:0] s_wdata,
  input  logic [1:0]             s_wvalid,
  output logic [1:0]             s_wready,
  output logic [1:0]             done,
  output logic [1:0]             err,
  key_wr_arb_if.master           axi
);

  state_e            state_q, state_d;
  logic [1:0]        gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [8:0]        beat_q;
  logic              ptr_q, ptr_d;
  logic [1:0]        arb_gnt;
  logic              sel;
  logic              beat_hs;
  logic              resp_hs;
  logic              tmo_hit;

  if (TMO_CYC < 1) begin : g_bad_tmo_cyc
    $error("key_wr_arb: TMO_CYC must be at least 1");
  end

  rr_arb2 u_arb (
    .req     (req),
    .en      (state_q == IDLE),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .ptr_nxt (ptr_d)
  );

  assign sel     = gnt_q[1];
  assign gnt     = gnt_q;
  assign beat_hs = (state_q == DATA) && axi.m_wvalid && axi.m_wready;
  assign resp_hs = (state_q == RESP) && axi.m_bvalid;

  // Pulses are suppressed while reset is asserted so an aborted burst never reports.
  assign done = (resp_hs && !areset) ? gnt_q : 2'b00;
  assign err  = (((resp_hs && (axi.m_bresp != RESP_OKAY)) || tmo_hit) && !areset) ? gnt_q : 2'b00;

`ifdef KEY_WR_ARB_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge aclk) begin
    if (areset || (state_q != RESP)) tmo_q <= '0;
    else                             tmo_q <= tmo_q + 1'b1;
  end

  // tmo_q counts completed RESP cycles, so this fires in the TMO_CYC-th one.
  assign tmo_hit = (state_q == RESP) && !axi.m_bvalid && (tmo_q == TMO_W'(TMO_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req)                        state_d = ADDR;
      ADDR:    if (axi.m_awready)               state_d = DATA;
      DATA:    if (beat_hs && axi.m_wlast)      state_d = RESP;
      RESP:    if (resp_hs || tmo_hit)          state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  always_comb begin
    axi.m_awaddr  = addr_q;
    axi.m_awlen   = len_q;
    axi.m_awvalid = (state_q == ADDR);
    axi.m_wvalid  = 1'b0;
    axi.m_wdata   = '0;
    s_wready      = 2'b00;
    if (state_q == DATA) begin
      axi.m_wvalid  = s_wvalid[sel];
      axi.m_wdata   = s_wdata[sel];
      s_wready[sel] = axi.m_wready;
    end
    axi.m_wstrb   = axi.m_wvalid ? '1 : '0;
    axi.m_wlast   = (state_q == DATA) && (beat_q == {1'b0, len_q});
    axi.m_bready  = (state_q == RESP);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      ptr_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      case (state_q)
        IDLE: if (|req) begin
          gnt_q  <= arb_gnt;
          addr_q <= req_addr[arb_gnt[1]];
          len_q  <= req_len[arb_gnt[1]];
          beat_q <= '0;
        end
        DATA: if (beat_hs) beat_q <= beat_q + 9'd1;
        RESP: if (resp_hs || tmo_hit) gnt_q <= 2'b00;
        default: ;
      endcase
    end
  end

endmodule : key_wr_arb
